// File: rtl/reg_serial_reader_pkg.sv
// Shared definitions for the REG serial reader: FSM state encodings and width limits.
package reg_serial_reader_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;

endpackage

// File: rtl/reg_serial_reader_bit_counter.sv
// Loadable down-counter that tracks the remaining data beats of a frame.
module ser_bit_counter #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/reg_serial_reader.sv
// Drains a parallel REG word onto a 1-bit valid/ready stream, with optional even parity.
module reg_serial_reader
  import reg_serial_reader_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] d,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic                 s_data,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic                 s_last,
  output logic                 busy
);

  localparam int CW = $clog2(DATAWIDTH + 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DATAWIDTH-1:0] r_shreg;
  logic [DATAWIDTH-1:0] w_shifted;
  logic                 r_par;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_zero;
  logic                 w_out_bit;

  ser_bit_counter #(
    .WIDTH(CW)
  ) u_cnt (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_load     (w_load),
    .i_load_val (CW'(DATAWIDTH - 1)),
    .i_dec      (w_shift),
    .o_zero     (w_zero)
  );

  // Shift toward the end being transmitted, zero-filling the vacated bit.
  assign w_shifted = (MSB_FIRST != 0) ? {r_shreg[DATAWIDTH-2:0], 1'b0}
                                      : {1'b0, r_shreg[DATAWIDTH-1:1]};
  assign w_out_bit = (MSB_FIRST != 0) ? r_shreg[DATAWIDTH-1] : r_shreg[0];

  assign busy    = (r_state != ST_IDLE);
  assign s_valid = busy;
  assign s_data  = (r_state == ST_PAR)  ? r_par :
                   (r_state == ST_DATA) ? w_out_bit : 1'b0;
  assign s_last  = (r_state == ST_PAR) ||
                   ((r_state == ST_DATA) && w_zero && (PARITY_EN == 0));

  // The final beat reopens the input so the next word loads without a bubble.
  assign d_ready = Rst && ((r_state == ST_IDLE) || (s_last && s_ready));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (d_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_ready) begin
          if (!w_zero) begin
            w_shift = 1'b1;
          end else if (PARITY_EN != 0) begin
            w_state_nxt = ST_PAR;
          end else if (d_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_PAR: begin
        if (s_ready) begin
          if (d_valid) begin
            w_load      = 1'b1;
            w_state_nxt = ST_DATA;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_shreg <= d;
        r_par   <= ^d;
      end else if (w_shift) begin
        r_shreg <= w_shifted;
      end
    end
  end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Bench for reg_serial_reader: frame-level model plus directed frames on two configurations.
module tb_reg_serial_reader;

  localparam int W = 8;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [W-1:0] d_in [2];
  logic [1:0] dv = 2'b00;
  logic [1:0] sr = 2'b00;
  logic [1:0] dr, sd, svl, sl, bz;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  // Instance 0: MSB first, no parity. Instance 1: LSB first, even parity.
  reg_serial_reader #(.DATAWIDTH(W), .MSB_FIRST(1), .PARITY_EN(0)) u_msb (
    .Clk(Clk), .Rst(Rst), .d(d_in[0]), .d_valid(dv[0]), .d_ready(dr[0]),
    .s_data(sd[0]), .s_valid(svl[0]), .s_ready(sr[0]), .s_last(sl[0]), .busy(bz[0]));

  reg_serial_reader #(.DATAWIDTH(W), .MSB_FIRST(0), .PARITY_EN(1)) u_lsbp (
    .Clk(Clk), .Rst(Rst), .d(d_in[1]), .d_valid(dv[1]), .d_ready(dr[1]),
    .s_data(sd[1]), .s_valid(svl[1]), .s_ready(sr[1]), .s_last(sl[1]), .busy(bz[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Expected stream: a FIFO of (bit, last) per instance, filled on word acceptance.
  logic ebit  [2][64];
  logic elast [2][64];
  int   head  [2] = '{0, 0};
  int   tail  [2] = '{0, 0};
  logic obit  [2][64];
  logic olast [2][64];
  int   ocyc  [2][64];
  int   on    [2] = '{0, 0};
  int   cyc = 0;

  logic       c_rst = 1'b0;
  logic [1:0] c_accs = 2'b00;
  logic [1:0] c_accd = 2'b00;
  logic [1:0] c_sd = 2'b00;
  logic [1:0] c_sl = 2'b00;
  logic [W-1:0] c_d [2];

  function automatic void push_frame(input int k, input logic [W-1:0] w);
    int par = (k == 1) ? 1 : 0;
    for (int i = 0; i < W; i++) begin
      ebit[k][tail[k] % 64]  = (k == 0) ? w[W-1-i] : w[i];
      elast[k][tail[k] % 64] = (i == W - 1) && (par == 0);
      tail[k]++;
    end
    if (par != 0) begin
      ebit[k][tail[k] % 64]  = ^w;
      elast[k][tail[k] % 64] = 1'b1;
      tail[k]++;
    end
  endfunction

  always @(negedge Clk) begin
    bit ev;
    bit edr;
    c_rst = Rst;
    for (int k = 0; k < 2; k++) begin
      if (!Rst) begin
        head[k] = tail[k];
        chk("rst_s_valid", int'(svl[k]), 0);
        chk("rst_s_last",  int'(sl[k]),  0);
        chk("rst_busy",    int'(bz[k]),  0);
        chk("rst_d_ready", int'(dr[k]),  0);
        c_accs[k] = 1'b0;
        c_accd[k] = 1'b0;
      end else begin
        ev = (tail[k] - head[k]) > 0;
        chk("s_valid", int'(svl[k]), int'(ev));
        chk("busy",    int'(bz[k]),  int'(ev));
        if (ev) begin
          chk("s_data", int'(sd[k]), int'(ebit[k][head[k] % 64]));
          chk("s_last", int'(sl[k]), int'(elast[k][head[k] % 64]));
          edr = elast[k][head[k] % 64] && sr[k];
        end else begin
          chk("s_last_idle", int'(sl[k]), 0);
          edr = 1'b1;
        end
        chk("d_ready", int'(dr[k]), int'(edr));
        c_accs[k] = ev && sr[k];
        c_accd[k] = dv[k] && edr;
        c_d[k]    = d_in[k];
        c_sd[k]   = sd[k];
        c_sl[k]   = sl[k];
      end
    end
  end

  always @(posedge Clk) begin
    cyc++;
    if (c_rst) begin
      for (int k = 0; k < 2; k++) begin
        if (c_accs[k]) begin
          obit[k][on[k] % 64]  = c_sd[k];
          olast[k][on[k] % 64] = c_sl[k];
          ocyc[k][on[k] % 64]  = cyc;
          on[k]++;
          head[k]++;
        end
        if (c_accd[k]) push_frame(k, c_d[k]);
      end
    end
  end

  function automatic int packbits(input int k, input int n, input bit lasts);
    logic [15:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[14:0], lasts ? olast[k][i] : obit[k][i]};
    return int'(r);
  endfunction

  task automatic wait_accept(input int k);
    int n = 0;
    @(negedge Clk);
    while (!dr[k] && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("word_accepted", int'(dr[k]), 1);
  endtask

  task automatic start(input int k, input logic [W-1:0] w);
    d_in[k] = w;
    dv[k]   = 1'b1;
    wait_accept(k);
    @(posedge Clk); #1;
    dv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    @(negedge Clk);
    while (bz[k] && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk("frame_drained", int'(bz[k]), 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    d_in[0] = '0;
    d_in[1] = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("t1_rst_s_valid", int'(svl[0]), 0);
    chk("t1_rst_busy",    int'(bz[0]),  0);
    chk("t1_rst_d_ready", int'(dr[0]),  0);
    Rst = 1'b1;
    #1;
    chk("t1_idle_d_ready", int'(dr[0]),  1);
    chk("t1_idle_s_valid", int'(svl[0]), 0);
    @(posedge Clk); #1;

    // Basic MSB-first frame
    sr[0] = 1'b1;
    on[0] = 0;
    start(0, 8'hA5);
    wait_idle(0);
    chk("t2_beats", on[0], 8);
    chk("t2_seq",   packbits(0, 8, 1'b0), 'b10100101);
    chk("t2_last",  packbits(0, 8, 1'b1), 'b00000001);

    // Stalls with s_ready pattern 1,0,0,1
    on[0] = 0;
    fork
      start(0, 8'h0A);
      for (int i = 0; i < 40; i++) begin
        sr[0] = (i % 4 == 0) || (i % 4 == 3);
        @(posedge Clk); #1;
      end
    join
    wait_idle(0);
    sr[0] = 1'b1;
    chk("t3_beats",   on[0], 8);
    chk("t3_seq",     packbits(0, 8, 1'b0), 'b00001010);
    chk("t3_last",    packbits(0, 8, 1'b1), 'b00000001);
    chk("t3_stalled", int'((ocyc[0][7] - ocyc[0][0]) > 7), 1);

    // Back-to-back frames
    on[0] = 0;
    d_in[0] = 8'h0A;
    dv[0]   = 1'b1;
    wait_accept(0);
    @(posedge Clk); #1;
    d_in[0] = 8'h05;
    wait_accept(0);
    @(posedge Clk); #1;
    dv[0] = 1'b0;
    wait_idle(0);
    chk("t4_beats",    on[0], 16);
    chk("t4_seq",      packbits(0, 16, 1'b0), 'h0A05);
    chk("t4_last",     packbits(0, 16, 1'b1), 'b0000000100000001);
    chk("t4_gapless",  ocyc[0][15] - ocyc[0][0], 15);

    // LSB-first with parity
    sr[1] = 1'b1;
    on[1] = 0;
    start(1, 8'h07);
    wait_idle(1);
    chk("t5_beats", on[1], 9);
    chk("t5_seq",   packbits(1, 9, 1'b0), 'b111000001);
    chk("t5_last",  packbits(1, 9, 1'b1), 'b000000001);

    // Reset in the middle of a frame
    on[0] = 0;
    start(0, 8'hFF);
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b0;
    #1;
    chk("t6_abort_s_valid", int'(svl[0]), 0);
    chk("t6_abort_busy",    int'(bz[0]),  0);
    chk("t6_abort_s_last",  int'(sl[0]),  0);
    chk("t6_partial_beats", on[0], 3);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    on[0] = 0;
    start(0, 8'h80);
    wait_idle(0);
    chk("t6_beats", on[0], 8);
    chk("t6_seq",   packbits(0, 8, 1'b0), 'b10000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d checks passed expected run to complete", n_pass);
    $fatal(1, "timeout");
  end

endmodule
